// File: rtl/mem_req_multicut.sv
// Request-path cut chain: NumCuts two-entry spill stages between initiator and memory.
// Optional stall counter port enabled by defining MEM_REQ_MULTICUT_PERF_EN.
module mem_req_multicut #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumCuts   = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   we_i,
    input  logic [DataWidth/8-1:0] strb_i,
    input  logic [DataWidth-1:0]   wdata_i,
    output logic                   req_o,
    input  logic                   gnt_i,
    output logic [AddrWidth-1:0]   addr_o,
    output logic                   we_o,
    output logic [DataWidth/8-1:0] strb_o,
    output logic [DataWidth-1:0]   wdata_o
`ifdef MEM_REQ_MULTICUT_PERF_EN
    ,
    output logic [31:0]            stall_cnt_o
`endif
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned PldWidth  = AddrWidth + 1 + StrbWidth + DataWidth;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_e;

    logic [PldWidth-1:0] pld_in;
    logic [PldWidth-1:0] pld_out;

    assign pld_in = {addr_i, we_i, strb_i, wdata_i};
    assign {addr_o, we_o, strb_o, wdata_o} = pld_out;

    if (NumCuts == 0) begin : g_bypass
        assign req_o   = req_i;
        assign gnt_o   = gnt_i;
        assign pld_out = pld_in;
    end else begin : g_cuts
        // Index k is the input side of stage k; index NumCuts is the downstream port.
        logic                vld [NumCuts+1];
        logic                rdy [NumCuts+1];
        logic [PldWidth-1:0] pld [NumCuts+1];

        assign vld[0]       = req_i;
        assign pld[0]       = pld_in;
        assign rdy[NumCuts] = gnt_i;
        assign gnt_o        = rdy[0];
        assign req_o        = vld[NumCuts];
        assign pld_out      = pld[NumCuts];

        for (genvar k = 0; k < NumCuts; k++) begin : g_stage
            state_e              state_q, state_d;
            logic [PldWidth-1:0] a_q, a_d;
            logic [PldWidth-1:0] b_q, b_d;
            logic                in_hs;
            logic                out_hs;

            assign in_hs  = vld[k] && (state_q != FULL);
            assign out_hs = (state_q != EMPTY) && rdy[k+1];

            always_comb begin
                state_d = state_q;
                a_d     = a_q;
                b_d     = b_q;
                unique case (state_q)
                    EMPTY: begin
                        if (in_hs) begin
                            state_d = HALF;
                            a_d     = pld[k];
                        end
                    end
                    HALF: begin
                        if (in_hs && !out_hs) begin
                            state_d = FULL;
                            b_d     = pld[k];
                        end else if (in_hs && out_hs) begin
                            a_d     = pld[k];
                        end else if (out_hs) begin
                            state_d = EMPTY;
                        end
                    end
                    FULL: begin
                        if (out_hs) begin
                            state_d = HALF;
                            a_d     = b_q;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    state_q <= EMPTY;
                    a_q     <= '0;
                    b_q     <= '0;
                end else begin
                    state_q <= state_d;
                    a_q     <= a_d;
                    b_q     <= b_d;
                end
            end

            // Ready and valid decode only registered state, so no path crosses a cut.
            assign rdy[k]   = (state_q != FULL);
            assign vld[k+1] = (state_q != EMPTY);
            assign pld[k+1] = a_q;
        end
    end

`ifdef MEM_REQ_MULTICUT_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (req_o && !gnt_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_req_multicut.sv
// Directed bench for mem_req_multicut with NumCuts = 0, 1, 2 and 3 instances.
module tb_mem_req_multicut;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // NumCuts = 2
    logic c2_req_i = 0, c2_gnt_o, c2_we_i = 0, c2_req_o, c2_gnt_i = 1, c2_we_o;
    logic [31:0] c2_addr_i = 0, c2_wdata_i = 0, c2_addr_o, c2_wdata_o;
    logic [3:0]  c2_strb_i = 0, c2_strb_o;
    // NumCuts = 3
    logic c3_req_i = 0, c3_gnt_o, c3_we_i = 0, c3_req_o, c3_gnt_i = 1, c3_we_o;
    logic [31:0] c3_addr_i = 0, c3_wdata_i = 0, c3_addr_o, c3_wdata_o;
    logic [3:0]  c3_strb_i = 0, c3_strb_o;
    // NumCuts = 0
    logic c0_req_i = 0, c0_gnt_o, c0_we_i = 0, c0_req_o, c0_gnt_i = 0, c0_we_o;
    logic [31:0] c0_addr_i = 0, c0_wdata_i = 0, c0_addr_o, c0_wdata_o;
    logic [3:0]  c0_strb_i = 0, c0_strb_o;
    // NumCuts = 1
    logic c1_req_i = 0, c1_gnt_o, c1_we_i = 0, c1_req_o, c1_gnt_i = 1, c1_we_o;
    logic [31:0] c1_addr_i = 0, c1_wdata_i = 0, c1_addr_o, c1_wdata_o;
    logic [3:0]  c1_strb_i = 0, c1_strb_o;
`ifdef MEM_REQ_MULTICUT_PERF_EN
    logic [31:0] c0_stall, c1_stall, c2_stall, c3_stall;
`endif

    mem_req_multicut #(.AddrWidth(32), .DataWidth(32), .NumCuts(2)) u_c2 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(c2_req_i), .gnt_o(c2_gnt_o), .addr_i(c2_addr_i), .we_i(c2_we_i),
        .strb_i(c2_strb_i), .wdata_i(c2_wdata_i),
        .req_o(c2_req_o), .gnt_i(c2_gnt_i), .addr_o(c2_addr_o), .we_o(c2_we_o),
        .strb_o(c2_strb_o), .wdata_o(c2_wdata_o)
`ifdef MEM_REQ_MULTICUT_PERF_EN
        , .stall_cnt_o(c2_stall)
`endif
    );

    mem_req_multicut #(.AddrWidth(32), .DataWidth(32), .NumCuts(3)) u_c3 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(c3_req_i), .gnt_o(c3_gnt_o), .addr_i(c3_addr_i), .we_i(c3_we_i),
        .strb_i(c3_strb_i), .wdata_i(c3_wdata_i),
        .req_o(c3_req_o), .gnt_i(c3_gnt_i), .addr_o(c3_addr_o), .we_o(c3_we_o),
        .strb_o(c3_strb_o), .wdata_o(c3_wdata_o)
`ifdef MEM_REQ_MULTICUT_PERF_EN
        , .stall_cnt_o(c3_stall)
`endif
    );

    mem_req_multicut #(.AddrWidth(32), .DataWidth(32), .NumCuts(0)) u_c0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(c0_req_i), .gnt_o(c0_gnt_o), .addr_i(c0_addr_i), .we_i(c0_we_i),
        .strb_i(c0_strb_i), .wdata_i(c0_wdata_i),
        .req_o(c0_req_o), .gnt_i(c0_gnt_i), .addr_o(c0_addr_o), .we_o(c0_we_o),
        .strb_o(c0_strb_o), .wdata_o(c0_wdata_o)
`ifdef MEM_REQ_MULTICUT_PERF_EN
        , .stall_cnt_o(c0_stall)
`endif
    );

    mem_req_multicut #(.AddrWidth(32), .DataWidth(32), .NumCuts(1)) u_c1 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_i(c1_req_i), .gnt_o(c1_gnt_o), .addr_i(c1_addr_i), .we_i(c1_we_i),
        .strb_i(c1_strb_i), .wdata_i(c1_wdata_i),
        .req_o(c1_req_o), .gnt_i(c1_gnt_i), .addr_o(c1_addr_o), .we_o(c1_we_o),
        .strb_o(c1_strb_o), .wdata_o(c1_wdata_o)
`ifdef MEM_REQ_MULTICUT_PERF_EN
        , .stall_cnt_o(c1_stall)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        req;
        logic        gnt;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        exp_req;
        logic        exp_gnt;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[4];
    int   idx;
    int   emitted;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 32'h0000_1234, 1'b1, 4'hF, 32'hCAFE_F00D,
                    1'b1, 1'b1, 32'h0000_1234, 1'b1, 4'hF, 32'hCAFE_F00D};
        vecs[1] = '{1'b1, 1'b0, 32'h8000_0040, 1'b0, 4'h0, 32'h1357_9BDF,
                    1'b1, 1'b0, 32'h8000_0040, 1'b0, 4'h0, 32'h1357_9BDF};
        vecs[2] = '{1'b0, 1'b1, 32'h0F0F_0F0C, 1'b1, 4'h5, 32'hA5A5_5A5A,
                    1'b0, 1'b1, 32'h0F0F_0F0C, 1'b1, 4'h5, 32'hA5A5_5A5A};
        vecs[3] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 4'hA, 32'h0000_0001,
                    1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 4'hA, 32'h0000_0001};

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_c2_req", 32'(c2_req_o), 32'd0);
        chk("rst_c2_gnt", 32'(c2_gnt_o), 32'd1);
        chk("rst_c2_addr", c2_addr_o, 32'd0);
        chk("rst_c2_wdata", c2_wdata_o, 32'd0);
        chk("rst_c2_we_strb", {27'd0, c2_we_o, c2_strb_o}, 32'd0);
        chk("rst_c3_req", 32'(c3_req_o), 32'd0);
        chk("rst_c3_gnt", 32'(c3_gnt_o), 32'd1);
        chk("rst_c1_req", 32'(c1_req_o), 32'd0);
        chk("rst_c1_gnt", 32'(c1_gnt_o), 32'd1);
        chk("rst_c1_addr", c1_addr_o, 32'd0);
        chk("rst_c1_wdata", c1_wdata_o, 32'd0);
        chk("rst_c1_we_strb", {27'd0, c1_we_o, c1_strb_o}, 32'd0);
`ifdef MEM_REQ_MULTICUT_PERF_EN
        chk("rst_stall_all", c0_stall | c1_stall | c2_stall | c3_stall, 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // NumCuts=2 single write: latency 2, one cycle only
        @(posedge clk); #1;
        c2_req_i = 1; c2_addr_i = 32'h100; c2_we_i = 1; c2_wdata_i = 32'hDEAD_BEEF;
        c2_strb_i = 4'hF; c2_gnt_i = 1;
        @(negedge clk);
        chk("single_gnt", 32'(c2_gnt_o), 32'd1);
        @(posedge clk); #1;
        c2_req_i = 0; c2_we_i = 0; c2_strb_i = 0; c2_wdata_i = 0;
        @(negedge clk);
        chk("single_lat1_req", 32'(c2_req_o), 32'd0);
        @(negedge clk);
        chk("single_lat2_req", 32'(c2_req_o), 32'd1);
        chk("single_addr", c2_addr_o, 32'h100);
        chk("single_wdata", c2_wdata_o, 32'hDEAD_BEEF);
        chk("single_we_strb", {27'd0, c2_we_o, c2_strb_o}, 32'h1F);
        @(negedge clk);
        chk("single_drop_req", 32'(c2_req_o), 32'd0);

        // NumCuts=2 back-to-back reads
        for (int j = 0; j < 12; j++) begin
            @(posedge clk); #1;
            c2_req_i  = (j < 8);
            c2_addr_i = (j < 8) ? 32'(j * 4) : 32'd0;
            @(negedge clk);
            if (j < 8) chk("b2b_gnt", 32'(c2_gnt_o), 32'd1);
            chk("b2b_req", 32'(c2_req_o), (j >= 2 && j < 10) ? 32'd1 : 32'd0);
            if (j >= 2 && j < 10) chk("b2b_addr", c2_addr_o, 32'((j - 2) * 4));
        end

        // NumCuts=2 backpressure: capacity 4, then drain in order
        idx = 0;
        emitted = 0;
        for (int j = 0; j < 40 && emitted < 5; j++) begin
            @(posedge clk); #1;
            c2_gnt_i = (j >= 8);
            if (idx < 5) begin
                c2_req_i = 1; c2_addr_i = 32'h200 + 32'(idx * 4); c2_we_i = 1;
                c2_wdata_i = 32'(idx) + 32'h7700; c2_strb_i = 4'h3;
            end else begin
                c2_req_i = 0; c2_we_i = 0;
            end
            @(negedge clk);
            if (j < 7) chk("bp_gnt", 32'(c2_gnt_o), (j < 4) ? 32'd1 : 32'd0);
            if (j == 7) chk("bp_accepted", 32'(idx), 32'd4);
            if (j >= 4 && j < 8) begin
                chk("bp_hold_req", 32'(c2_req_o), 32'd1);
                chk("bp_hold_addr", c2_addr_o, 32'h200);
            end
            if (c2_req_i && c2_gnt_o) idx++;
            if (c2_req_o && c2_gnt_i) begin
                chk("bp_order_addr", c2_addr_o, 32'h200 + 32'(emitted * 4));
                chk("bp_order_wdata", c2_wdata_o, 32'(emitted) + 32'h7700);
                emitted++;
            end
        end
        chk("bp_emitted", 32'(emitted), 32'd5);
        chk("bp_all_accepted", 32'(idx), 32'd5);
        @(posedge clk); #1;
        c2_req_i = 0; c2_we_i = 0;

        // NumCuts=3 reset with buffered requests
        c3_gnt_i = 0;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            c3_req_i = 1; c3_addr_i = 32'h300 + 32'(j * 4);
        end
        @(posedge clk); #1;
        c3_req_i = 0;
        @(negedge clk);
        chk("rst3_pre_req", 32'(c3_req_o), 32'd1);
        chk("rst3_pre_addr", c3_addr_o, 32'h300);
        rst_n = 1'b0;
        #1;
        chk("rst3_req", 32'(c3_req_o), 32'd0);
        chk("rst3_gnt", 32'(c3_gnt_o), 32'd1);
        chk("rst3_addr", c3_addr_o, 32'd0);
        chk("rst3_fields", c3_wdata_o | {27'd0, c3_we_o, c3_strb_o}, 32'd0);
        #2 rst_n = 1'b1;
        c3_gnt_i = 1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("rst3_no_stale", 32'(c3_req_o), 32'd0);
        end

        // NumCuts=0 pass-through table
        for (int i = 0; i < 4; i++) begin
            c0_req_i = vecs[i].req; c0_gnt_i = vecs[i].gnt; c0_addr_i = vecs[i].addr;
            c0_we_i = vecs[i].we; c0_strb_i = vecs[i].strb; c0_wdata_i = vecs[i].wdata;
            #1;
            chk("c0_req", 32'(c0_req_o), 32'(vecs[i].exp_req));
            chk("c0_gnt", 32'(c0_gnt_o), 32'(vecs[i].exp_gnt));
            chk("c0_addr", c0_addr_o, vecs[i].exp_addr);
            chk("c0_we", 32'(c0_we_o), 32'(vecs[i].exp_we));
            chk("c0_strb", 32'(c0_strb_o), 32'(vecs[i].exp_strb));
            chk("c0_wdata", c0_wdata_o, vecs[i].exp_wdata);
        end
        c0_req_i = 0;

        // NumCuts=1 stall sequence
        @(posedge clk); #1;
        c1_req_i = 1; c1_addr_i = 32'h440; c1_gnt_i = 0;
        @(posedge clk); #1;
        c1_req_i = 0;
        @(negedge clk);
        chk("c1_req_lat1", 32'(c1_req_o), 32'd1);
        chk("c1_addr", c1_addr_o, 32'h440);
        repeat (10) @(posedge clk);
        #1 c1_gnt_i = 1;
        @(posedge clk); #1;
        chk("c1_req_drained", 32'(c1_req_o), 32'd0);
`ifdef MEM_REQ_MULTICUT_PERF_EN
        chk("stall_cnt", c1_stall, 32'd10);
        rst_n = 1'b0;
        #1;
        chk("stall_cnt_rst", c1_stall, 32'd0);
        #2 rst_n = 1'b1;
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
